// File: rtl/snake_pkg.sv
// snake_pkg: shared game-state encoding and counter widths for the snake controller
package snake_pkg;
    localparam int SCORE_W = 8;
    localparam int TIME_W = 5;
    typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, PAUSE = 3'd2, OVER = 3'd3} mode_t;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: one-cycle pulse on a rising button level, armed one cycle after reset
module btn_edge (
    input  logic clk,
    input  logic nRst_i,
    input  logic level,
    output logic pulse
);
    logic prev, armed;
    // a level already high when reset releases is captured before arming, so it never reads as a press
    always_ff @(posedge clk or negedge nRst_i)
        if (!nRst_i) begin
            prev <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev <= level;
            armed <= 1'b1;
        end
    assign pulse = armed & level & ~prev;
endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game-mode FSM, move-tick prescaler with speed-up, score and elapsed-time counters
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 25,
    parameter int MIN_DIV = 5,
    parameter int DIV_STEP = 4,
    parameter int CLK_HZ = 100
) (
    input  logic               clk,
    input  logic               nRst_i,
    input  logic               start_i,
    input  logic               pause_i,
    input  logic               collide_i,
    input  logic               ate_i,
    output logic [2:0]         mode_o,
    output logic               tick_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [TIME_W-1:0]  time_o
);
    localparam int W = $clog2(TICK_DIV + 1);
    localparam int SW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    mode_t state, nxt;
    logic start_p, pause_p, run_go, ate_ok, sec_wrap;
    logic [W-1:0] period, cnt;
    logic [SW-1:0] sec;
    btn_edge u_start (.clk(clk), .nRst_i(nRst_i), .level(start_i), .pulse(start_p));
    btn_edge u_pause (.clk(clk), .nRst_i(nRst_i), .level(pause_i), .pulse(pause_p));
    // prescalers advance only on cycles that stay in RUN (no collision, no pause press)
    assign run_go = (state == RUN) & ~collide_i & ~pause_p;
    assign ate_ok = (state == RUN) & ~collide_i & ate_i & (score_o != '1);
    assign sec_wrap = (sec == SW'(CLK_HZ - 1));
    assign mode_o = state;
    // state register
    always_ff @(posedge clk or negedge nRst_i)
        if (!nRst_i) state <= IDLE;
        else state <= nxt;
    // next-state and move strobe; collision outranks pause in RUN
    always_comb begin
        nxt = state;
        tick_o = 1'b0;
        case (state)
            IDLE: nxt = start_p ? RUN : IDLE;
            RUN: nxt = collide_i ? OVER : (pause_p ? PAUSE : RUN);
            PAUSE: nxt = pause_p ? RUN : PAUSE;
            OVER: nxt = start_p ? IDLE : OVER;
            default: nxt = IDLE;
        endcase
        tick_o = run_go && (cnt >= period - W'(1));
    end
    // counters: cleared on a new game, score speeds the snake up every fourth food
    always_ff @(posedge clk or negedge nRst_i)
        if (!nRst_i) begin
            cnt <= '0;
            sec <= '0;
            score_o <= '0;
            time_o <= '0;
            period <= W'(TICK_DIV);
        end else if (state == IDLE && start_p) begin
            cnt <= '0;
            sec <= '0;
            score_o <= '0;
            time_o <= '0;
            period <= W'(TICK_DIV);
        end else begin
            if (run_go) begin
                cnt <= tick_o ? '0 : cnt + W'(1);
                sec <= sec_wrap ? '0 : sec + SW'(1);
                if (sec_wrap) time_o <= time_o + TIME_W'(1);
            end
            if (ate_ok) begin
                score_o <= score_o + SCORE_W'(1);
                if (score_o[1:0] == 2'b11)
                    period <= (int'(period) >= MIN_DIV + DIV_STEP) ? W'(int'(period) - DIV_STEP) : W'(MIN_DIV);
            end
        end
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed and random stimulus checked against a behavioural game model
module tb_snake_game_ctrl;
    logic clk = 1'b0, nRst_i = 1'b0, start_i = 1'b0, pause_i = 1'b0, collide_i = 1'b0, ate_i = 1'b0;
    logic [2:0] mode_o;
    logic tick_o;
    logic [7:0] score_o;
    logic [4:0] time_o;
    int checks = 0, errors = 0, cyc = 0;
    int m_mode, m_score, m_run, m_since, m_period;
    bit m_sprev, m_pprev, m_armed;
    int tq[$];

    snake_game_ctrl #(.TICK_DIV(8), .MIN_DIV(4), .DIV_STEP(2), .CLK_HZ(10)) dut (
        .clk(clk), .nRst_i(nRst_i), .start_i(start_i), .pause_i(pause_i),
        .collide_i(collide_i), .ate_i(ate_i), .mode_o(mode_o), .tick_o(tick_o),
        .score_o(score_o), .time_o(time_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_score = 0; m_run = 0; m_since = 0; m_period = 8;
        m_sprev = 0; m_pprev = 0; m_armed = 0;
    endtask

    // one clock: check outputs mid-cycle against the model, then advance the model past the edge
    task automatic step();
        bit sp, pp, go, tk;
        @(negedge clk);
        sp = m_armed && start_i && !m_sprev;
        pp = m_armed && pause_i && !m_pprev;
        go = (m_mode == 1) && !collide_i && !pp;
        tk = go && (m_since + 1 >= m_period);
        chk("mode", mode_o, m_mode);
        chk("tick", tick_o, tk);
        chk("score", score_o, m_score);
        chk("time", time_o, (m_run / 10) % 32);
        if (tick_o === 1'b1) tq.push_back(cyc);
        cyc++;
        if (m_mode == 0) begin
            if (sp) begin
                m_mode = 1; m_score = 0; m_run = 0; m_since = 0; m_period = 8;
            end
        end else begin
            if (go) begin
                m_run++;
                m_since = tk ? 0 : m_since + 1;
            end
            if (m_mode == 1 && !collide_i && ate_i && m_score < 255) begin
                m_score++;
                if (m_score % 4 == 0) m_period = (m_period - 2 < 4) ? 4 : m_period - 2;
            end
            if (m_mode == 1) m_mode = collide_i ? 3 : (pp ? 2 : 1);
            else if (m_mode == 2) m_mode = pp ? 1 : 2;
            else if (m_mode == 3) m_mode = sp ? 0 : 3;
        end
        m_sprev = start_i; m_pprev = pause_i; m_armed = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        start_i = 1'b1; step(); start_i = 1'b0;
    endtask

    task automatic press_pause();
        pause_i = 1'b1; step(); pause_i = 1'b0;
    endtask

    task automatic pulse_ate();
        ate_i = 1'b1; step(); ate_i = 1'b0; step();
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 40 && tq.size() == 0; i++) step();
        chk("tick_seen", tq.size() > 0, 1);
    endtask

    initial begin
        int s, n;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mode", mode_o, 0);
        chk("rst_tick", tick_o, 0);
        chk("rst_score", score_o, 0);
        chk("rst_time", time_o, 0);
        nRst_i = 1'b1;
        repeat (3) step();
        // start, ticks at 8/16/24 cycles after the press, time after 10 run cycles
        pause_i = 1'b1; start_i = 1'b1; s = cyc; step(); start_i = 1'b0; pause_i = 1'b0;
        chk("run_entry", mode_o, 1);
        tq.delete();
        repeat (26) step();
        chk("tick_count", tq.size(), 3);
        if (tq.size() >= 3) begin
            chk("tick1", tq[0] - s, 8);
            chk("tick2", tq[1] - s, 16);
            chk("tick3", tq[2] - s, 24);
        end
        // pause at count 3, hold, resume: next tick 5 cycles after the resume press
        tq.delete();
        wait_tick();
        repeat (3) step();
        press_pause();
        chk("paused", mode_o, 2);
        tq.delete();
        repeat (20) step();
        chk("pause_noticks", tq.size(), 0);
        s = cyc;
        press_pause();
        chk("resumed", mode_o, 1);
        wait_tick();
        if (tq.size() > 0) chk("resume_tick", tq[0] - s, 5);
        // collision on a tick cycle together with a pause press
        pulse_ate();
        pulse_ate();
        n = 0;
        while (m_since != m_period - 1 && n < 20) begin step(); n++; end
        collide_i = 1'b1; pause_i = 1'b1;
        step();
        collide_i = 1'b0; pause_i = 1'b0;
        chk("over", mode_o, 3);
        chk("over_score", score_o, 2);
        repeat (3) step();
        press_start();
        chk("back_idle", mode_o, 0);
        chk("idle_score", score_o, 2);
        step();
        press_start();
        chk("restart", mode_o, 1);
        chk("restart_score", score_o, 0);
        // speed-up: 4 foods -> spacing 6, 12 foods -> spacing floors at 4
        repeat (4) pulse_ate();
        tq.delete();
        repeat (20) step();
        chk("sp6_n", tq.size() >= 2, 1);
        if (tq.size() >= 2) chk("spacing6", tq[1] - tq[0], 6);
        repeat (8) pulse_ate();
        chk("score12", score_o, 12);
        tq.delete();
        repeat (20) step();
        chk("sp4_n", tq.size() >= 2, 1);
        if (tq.size() >= 2) chk("spacing4", tq[1] - tq[0], 4);
        // asynchronous reset mid-run, start held through release must not start
        #2 nRst_i = 1'b0;
        #1;
        chk("arst_mode", mode_o, 0);
        chk("arst_tick", tick_o, 0);
        chk("arst_score", score_o, 0);
        chk("arst_time", time_o, 0);
        model_reset();
        start_i = 1'b1;
        @(posedge clk);
        #1;
        nRst_i = 1'b1;
        repeat (5) step();
        chk("held_idle", mode_o, 0);
        start_i = 1'b0;
        step();
        press_start();
        chk("repress_run", mode_o, 1);
        // score saturation and time wrap over 320 run cycles
        ate_i = 1'b1;
        repeat (260) step();
        ate_i = 1'b0;
        repeat (50) step();
        chk("score_sat", score_o, 255);
        chk("time31", time_o, 31);
        repeat (10) step();
        chk("time_wrap", time_o, 0);
        // random play
        for (int i = 0; i < 1500; i++) begin
            start_i = ($urandom_range(0, 19) == 0);
            pause_i = ($urandom_range(0, 24) == 0);
            collide_i = ($urandom_range(0, 199) == 0);
            ate_i = ($urandom_range(0, 3) == 0);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
